// File: rtl/serial_mult_ctrl_if.sv
// Handshake bundle between a multiply requester and the serial multiplier.
// Latency: none, wires only.
// Backpressure: requester watches busy; start is ignored while busy is high.
interface serial_mult_ctrl_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  // Requester side: issues operands, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, product
  );

  // Multiplier side: consumes operands, reports status and result.
  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/serial_mult_ctrl.sv
// Unsigned shift-add serial multiplier: one N-bit lookahead adder stepped once per clock.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+N, IDLE after k+N+1.
// Backpressure: busy is high in RUN and DONE; start is dropped (not queued) while busy.

// Combinational N-bit adder with flattened carry lookahead.
module cla_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;

  assign gen  = in1 & in2;
  assign prop = in1 ^ in2;

  // Each carry is built from generate/propagate terms of all lower bits.
  always_comb begin
    logic term;
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) begin
        term = gen[j] | (prop[j] & term);
      end
      carry[i+1] = term;
    end
  end

  assign sum  = prop ^ carry[N-1:0];
  assign cout = carry[N];
endmodule

module serial_mult_ctrl #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_mult_ctrl_if.slave    bus
);
  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          load;
  logic          step;
  logic          busy;
  logic          done;

  logic [N-1:0]  mcand;
  logic [N-1:0]  acc;
  logic [N-1:0]  mq;
  logic [CW-1:0] cnt;

  logic [N-1:0]  addend;
  logic [N-1:0]  sum;
  logic          cout;

  // The low multiplier bit selects whether this step adds the multiplicand.
  assign addend = mq[0] ? mcand : '0;

  cla_adder #(.N(N)) u_adder (
    .in1  (acc),
    .in2  (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and status outputs.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operand capture and one add-shift step per RUN cycle; cout lands in acc's top bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
    end else if (load) begin
      mcand <= bus.a;
      mq    <= bus.b;
      acc   <= '0;
      cnt   <= '0;
    end else if (step) begin
      {acc, mq} <= {cout, sum, mq[N-1:1]};
      cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = {acc, mq};
endmodule

// File: tb/tb_serial_mult_ctrl.sv
// Scoreboard bench for serial_mult_ctrl: directed operands, expected products queued at issue.
// Latency: checks sampled on the falling edge, results popped when done is seen.
// Backpressure: stimulus waits for busy low before issuing each start.
module tb_serial_mult_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_mult_ctrl_if #(.N(N)) bus ();

  serial_mult_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  logic [15:0] sb[$];
  int          done_count = 0;
  int          cyc = 0;
  int          last_done_cyc = -100;
  int          prev_done_cyc = -100;
  logic        done_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops one expected product per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      done_d = 1'b0;
    end else begin
      if (bus.done) begin
        done_count++;
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        check("done_not_back_to_back", done_d, 1'b0);
        check("done_expected", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) check("product", bus.product, sb.pop_front());
      end
      done_d = bus.done;
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 100 && bus.busy; i++) @(negedge clk);
    check("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic do_mult(input logic [7:0] x, input logic [7:0] y);
    wait_idle();
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    sb.push_back(16'(x) * 16'(y));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain_timeout", sb.size(), 0);
  endtask

  logic [7:0] ta[4] = '{8'd255, 8'd0,   8'd200, 8'd1};
  logic [7:0] tb[4] = '{8'd255, 8'd200, 8'd1,   8'd0};

  initial begin
    int n;
    int d0;
    logic [7:0] ra;
    logic [7:0] rb;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_product", bus.product, 16'd0);
    rst = 1'b0;

    // 5*3: busy for N+1 cycles, then idle holding the result.
    do_mult(8'd5, 8'd3);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else break;
    end
    check("busy_cycles", n, 9);
    check("idle_product", bus.product, 16'd15);
    check("idle_done_low", bus.done, 1'b0);
    drain();

    // Corner operands.
    for (int i = 0; i < 4; i++) begin
      do_mult(ta[i], tb[i]);
      drain();
    end
    wait_idle();
    check("hold_last_result", bus.product, 16'd0);

    // Start pulses during RUN and DONE are dropped.
    d0 = done_count;
    do_mult(8'd12, 8'd3);
    bus.start = 1'b1;
    bus.a     = 8'd99;
    bus.b     = 8'd99;
    repeat (N + 1) @(posedge clk);
    #1 bus.start = 1'b0;
    drain();
    repeat (15) @(negedge clk);
    check("single_done", done_count - d0, 1);
    check("ignored_start_product", bus.product, 16'd36);

    // Reset mid-operation after 4 steps.
    do_mult(8'd25, 8'd7);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_product", bus.product, 16'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    do_mult(8'd25, 8'd7);
    drain();

    // Start held high: back-to-back multiplies every N+2 clocks.
    wait_idle();
    bus.start = 1'b1;
    bus.a     = 8'd10;
    bus.b     = 8'd20;
    sb.push_back(16'd200);
    @(posedge clk);
    #1;
    bus.a = 8'd4;
    bus.b = 8'd14;
    sb.push_back(16'd56);
    repeat (N + 2) @(posedge clk);
    #1 bus.start = 1'b0;
    drain();
    check("done_period", last_done_cyc - prev_done_cyc, N + 2);

    // Random sweep.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_mult(ra, rb);
    end
    drain();
    repeat (15) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule
